// File: rtl/alu_core.sv
// rtl/alu_core.sv - parametrised ALU execute stage with operand latches and shift-add multiply
// Single-cycle logic/arith/shift ops complete in IDLE; MUL iterates WIDTH edges in MUL state.

module alu_core #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_alu_core,
  input  logic [WIDTH-1:0] dmem_data,
  input  logic [WIDTH-1:0] ir_operand,
  input  logic [1:0]       cu_A,
  input  logic [1:0]       cu_B,
  input  logic [3:0]       opcode,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] RH,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_MUL = 4'd7;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   r_q, r_d;
  logic [WIDTH-1:0]   rh_q, rh_d;
  logic               z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [SW-1:0]      cnt_q, cnt_d;

  logic [WIDTH-1:0]   op_r;
  logic               op_c, op_v;
  logic [WIDTH:0]     sum, diff;
  logic [WIDTH:0]     shl_ext, shr_ext;
  logic [SW-1:0]      amt;
  logic [2*WIDTH-1:0] mul_acc;

  always_comb begin
    a_d = a_q;
    case (cu_A)
      2'b10:   a_d = dmem_data;
      2'b11:   a_d = ir_operand;
      default: a_d = a_q;
    endcase
    b_d = b_q;
    case (cu_B)
      2'b10:   b_d = dmem_data;
      2'b11:   b_d = ir_operand;
      default: b_d = b_q;
    endcase
  end

  // Extended shifts put the last bit shifted out at a fixed position (0 for amount 0).
  assign amt     = b_q[SW-1:0];
  assign sum     = {1'b0, a_q} + {1'b0, b_q};
  assign diff    = {1'b0, a_q} - {1'b0, b_q};
  assign shl_ext = {1'b0, a_q} << amt;
  assign shr_ext = {a_q, 1'b0} >> amt;
  assign mul_acc = acc_q + (mplier_q[0] ? mcand_q : {2*WIDTH{1'b0}});

  always_comb begin
    op_r = '0;
    op_c = 1'b0;
    op_v = 1'b0;
    case (opcode)
      OP_ADD: begin
        op_r = sum[WIDTH-1:0];
        op_c = sum[WIDTH];
        op_v = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        op_r = diff[WIDTH-1:0];
        op_c = diff[WIDTH];
        op_v = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND: op_r = a_q & b_q;
      OP_OR:  op_r = a_q | b_q;
      OP_XOR: op_r = a_q ^ b_q;
      OP_SHL: begin
        op_r = shl_ext[WIDTH-1:0];
        op_c = shl_ext[WIDTH];
      end
      OP_SHR: begin
        op_r = shr_ext[WIDTH:1];
        op_c = shr_ext[0];
      end
      default: begin
        op_r = '0;
        op_c = 1'b0;
        op_v = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    rh_d     = rh_q;
    z_d      = z_q;
    n_d      = n_q;
    c_d      = c_q;
    v_d      = v_q;
    done_d   = 1'b0;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (opcode == OP_MUL) begin
            mcand_d  = {{WIDTH{1'b0}}, a_q};
            mplier_d = b_q;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = S_MUL;
          end else begin
            r_d    = op_r;
            rh_d   = '0;
            z_d    = (op_r == '0);
            n_d    = op_r[WIDTH-1];
            c_d    = op_c;
            v_d    = op_v;
            done_d = 1'b1;
          end
        end
      end
      S_MUL: begin
        // The final iteration writes the product directly rather than into acc_q.
        if (cnt_q == SW'(WIDTH - 1)) begin
          r_d     = mul_acc[WIDTH-1:0];
          rh_d    = mul_acc[2*WIDTH-1:WIDTH];
          z_d     = (mul_acc[WIDTH-1:0] == '0);
          n_d     = mul_acc[WIDTH-1];
          c_d     = (mul_acc[2*WIDTH-1:WIDTH] != '0);
          v_d     = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          acc_d    = mul_acc;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + SW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_alu_core) begin
    if (reset_alu_core) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      rh_q     <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      done_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      r_q      <= r_d;
      rh_q     <= rh_d;
      z_q      <= z_d;
      n_q      <= n_d;
      c_q      <= c_d;
      v_q      <= v_d;
      done_q   <= done_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy   = (state_q == S_MUL);
  assign done   = done_q;
  assign R      = r_q;
  assign RH     = rh_q;
  assign flag_z = z_q;
  assign flag_n = n_q;
  assign flag_c = c_q;
  assign flag_v = v_q;

endmodule

// File: tb/tb_alu_core.sv
// tb/tb_alu_core.sv - scoreboard bench for alu_core with directed vectors
// Stimulus pushes expected results; a negedge monitor pops them when done pulses.

module tb_alu_core;

  localparam int W = 8;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_MUL = 4'd7;

  logic         clk = 1'b0;
  logic         reset_alu_core;
  logic [W-1:0] dmem_data, ir_operand;
  logic [1:0]   cu_A, cu_B;
  logic [3:0]   opcode;
  logic         start;
  logic         busy, done;
  logic [W-1:0] R, RH;
  logic         flag_z, flag_n, flag_c, flag_v;

  alu_core #(.WIDTH(W)) dut (
    .clk            (clk),
    .reset_alu_core (reset_alu_core),
    .dmem_data      (dmem_data),
    .ir_operand     (ir_operand),
    .cu_A           (cu_A),
    .cu_B           (cu_B),
    .opcode         (opcode),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .R              (R),
    .RH             (RH),
    .flag_z         (flag_z),
    .flag_n         (flag_n),
    .flag_c         (flag_c),
    .flag_v         (flag_v)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // flags packed as {z, n, c, v}
  typedef struct {
    int           cyc;
    logic [W-1:0] r;
    logic [W-1:0] rh;
    logic [3:0]   f;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset_alu_core && done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
      end else begin
        e = q.pop_front();
        check("done_cycle", cyc, e.cyc);
        check("R", R, e.r);
        check("RH", RH, e.rh);
        check("flags_zncv", {flag_z, flag_n, flag_c, flag_v}, e.f);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [W-1:0] a, input logic [W-1:0] b);
    dmem_data  = a;
    ir_operand = b;
    cu_A = 2'b10;
    cu_B = 2'b11;
    step();
    cu_A = 2'b00;
    cu_B = 2'b01;
  endtask

  task automatic issue(input logic [3:0] op, input int lat,
                       input logic [W-1:0] r, input logic [W-1:0] rh, input logic [3:0] f);
    exp_t e;
    opcode = op;
    start  = 1'b1;
    step();
    start  = 1'b0;
    e.cyc = cyc + lat;
    e.r   = r;
    e.rh  = rh;
    e.f   = f;
    q.push_back(e);
  endtask

  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] r, input logic [W-1:0] rh, input logic [3:0] f);
    load(a, b);
    issue(op, 0, r, rh, f);
    step();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_R"}, R, 0);
    check({tag, "_RH"}, RH, 0);
    check({tag, "_flags"}, {flag_z, flag_n, flag_c, flag_v}, 0);
  endtask

  initial begin
    reset_alu_core = 1'b1;
    dmem_data = '0; ir_operand = '0;
    cu_A = 2'b00; cu_B = 2'b00;
    opcode = OP_ADD; start = 1'b0;
    step();
    step();
    reset_alu_core = 1'b0;
    check_reset_state("reset");

    // Latch hold: A keeps 0x5A while dmem changes; B from ir_operand
    dmem_data = 8'h5A; cu_A = 2'b10; step();
    dmem_data = 8'hFF; cu_A = 2'b01;
    step(); step(); step();
    ir_operand = 8'h3C; cu_A = 2'b00; cu_B = 2'b11; step();
    cu_B = 2'b00;
    issue(OP_ADD, 0, 8'h96, 8'h00, 4'b0101);
    step();

    run_op(OP_ADD, 8'hF0, 8'h20, 8'h10, 8'h00, 4'b0010);
    run_op(OP_SUB, 8'h80, 8'h01, 8'h7F, 8'h00, 4'b0001);
    run_op(OP_SUB, 8'h01, 8'h02, 8'hFF, 8'h00, 4'b0110);
    run_op(OP_AND, 8'h3C, 8'h0F, 8'h0C, 8'h00, 4'b0000);
    run_op(OP_OR,  8'h3C, 8'h0F, 8'h3F, 8'h00, 4'b0000);
    run_op(OP_XOR, 8'h3C, 8'h0F, 8'h33, 8'h00, 4'b0000);
    run_op(OP_AND, 8'hF0, 8'h0F, 8'h00, 8'h00, 4'b1000);
    run_op(OP_SHL, 8'h81, 8'h01, 8'h02, 8'h00, 4'b0010);
    run_op(OP_SHR, 8'h81, 8'h09, 8'h40, 8'h00, 4'b0010);
    run_op(OP_SHL, 8'h81, 8'h00, 8'h81, 8'h00, 4'b0100);
    run_op(OP_SHL, 8'h81, 8'h07, 8'h80, 8'h00, 4'b0100);
    run_op(OP_SHR, 8'h81, 8'h08, 8'h81, 8'h00, 4'b0100);
    run_op(4'hF,   8'h81, 8'h01, 8'h00, 8'h00, 4'b1000);

    // MUL with ignored start and operand reloads while busy, then back-to-back ADD
    load(8'h12, 8'h34);
    issue(OP_MUL, W, 8'hA8, 8'h03, 4'b0110);
    check("mul_busy_rise", busy, 1);
    step();
    check("mul_busy", busy, 1);
    start = 1'b1; opcode = OP_ADD;
    dmem_data = 8'h01; ir_operand = 8'h02; cu_A = 2'b10; cu_B = 2'b11;
    step();
    start = 1'b0; cu_A = 2'b00; cu_B = 2'b00;
    for (int i = 0; i < W - 3; i++) begin
      check("mul_busy", busy, 1);
      step();
    end
    check("mul_busy_last", busy, 1);
    step();
    check("mul_busy_fall", busy, 0);
    check("mul_done_seen", done, 1);
    issue(OP_ADD, 0, 8'h03, 8'h00, 4'b0000);
    step();

    // Reset three cycles into a multiply aborts it without done
    load(8'h12, 8'h34);
    opcode = OP_MUL; start = 1'b1; step(); start = 1'b0;
    step(); step(); step();
    reset_alu_core = 1'b1;
    #2;
    check_reset_state("abort");
    step();
    reset_alu_core = 1'b0;
    step();
    check_reset_state("post_abort");

    load(8'hFF, 8'hFF);
    issue(OP_MUL, W, 8'h01, 8'hFE, 4'b0010);
    for (int i = 0; i < W + 1; i++) step();
    load(8'h10, 8'h10);
    issue(OP_MUL, W, 8'h00, 8'h01, 4'b1010);

    for (int i = 0; i < 40 && q.size() != 0; i++) step();
    step();
    check("queue_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_core.md
# alu_core

Parametrised successor of the 8-bit ALU datapath, and the execute stage for the wider-word CPU variants. It keeps the A/B operand-latch scheme: each latch loads from data memory, from the instruction operand, or holds. It adds a WIDTH parameter, shift operations, a multi-cycle shift-add multiply with a high-half result, a start/busy/done handshake, and a registered flag set (Z, N, C, V) for the control unit's branch logic.

## Interface
- WIDTH, 8, datapath width in bits; must be at least 4 and a power of two.
- clk  input  1  rising-edge clock.
- reset_alu_core  input  1  asynchronous, active-high reset.
- dmem_data  input  WIDTH  data-memory read value.
- ir_operand  input  WIDTH  immediate field of the instruction register.
- cu_A  input  2  A-latch select: 2'b10 loads dmem_data, 2'b11 loads ir_operand, 2'b00 and 2'b01 hold.
- cu_B  input  2  B-latch select, same encoding as cu_A.
- opcode  input  4  operation, using the shared ADD/SUB/AND/OR/XOR/SHL/SHR/MUL opcode macros.
- start  input  1  request to execute opcode on the current A and B.
- busy  output  1  multiply in progress; start is ignored while high.
- done  output  1  one-cycle pulse; R, RH and the flags were updated on this edge.
- R  output  WIDTH  result, low half for MUL.
- RH  output  WIDTH  MUL high half; cleared by every non-MUL operation.
- flag_z, flag_n, flag_c, flag_v  output  1 each  zero, negative, carry/borrow, signed overflow.

## Operation
- Reset values: A, B, R, RH, all flags, busy and done are 0; the FSM is in IDLE.
- A and B update on every edge per cu_A/cu_B, including while busy. A multiply copies its operands at start, so later A/B loads do not affect it.
- FSM states:
  - IDLE: start=1 with a single-cycle opcode writes the result and pulses done on that edge, staying in IDLE. start=1 with MUL loads multiplicand=A, multiplier=B, accumulator=0, count=0, and moves to MUL.
  - MUL: one shift-add iteration per edge. After WIDTH iterations, {RH,R} takes the 2·WIDTH-bit product, done pulses, and the FSM returns to IDLE.
- ADD: R = A+B. C = carry out of the MSB. V = signed overflow.
- SUB: R = A−B. C = 1 when there is a borrow (A<B unsigned). V = signed overflow.
- AND, OR, XOR: C = 0, V = 0.
- SHL, SHR (logical): the shift amount is B[log2(WIDTH)−1:0], so it wraps modulo WIDTH. C = last bit shifted out; amount 0 gives C = 0. V = 0.
- MUL: unsigned product. C = (RH ≠ 0). V = 0.
- Unknown opcode: R = 0, RH = 0, Z = 1, N, C and V = 0, and done still pulses.
- All ops: Z = (R == 0) and N = R[WIDTH−1], both computed on the written R.
- Flags, R and RH change only on edges where done goes high; otherwise they hold.

## Timing
- start is sampled at the rising edge. A and B are the register values at that edge, not the values loaded on the same edge.
- Single-cycle ops: latency 1. Results and done=1 appear after the sampling edge.
- MUL: busy rises after the accepting edge. Results appear and busy falls WIDTH edges after acceptance (8 cycles at WIDTH=8), with done=1 for that one cycle.
- start while busy: ignored, with no queueing.
- start in the cycle where done=1: accepted, allowing back-to-back issue.
- Reset asserted mid-MUL: immediate abort. All outputs return to their reset values and no done is produced.

## Test plan
- Reset then latch loads: dmem_data=0x5A with cu_A=10, then cu_A=01 for 3 cycles → A stays 0x5A. ir_operand=0x3C with cu_B=11 → B=0x3C.
- ADD and SUB: A=0xF0, B=0x20, ADD → R=0x10, C=1, V=0, Z=0, done for 1 cycle. A=0x80, B=0x01, SUB → R=0x7F, C=0, V=1, N=0.
- Shifts: A=0x81, B=1, SHL → R=0x02, C=1. A=0x81, B=9, SHR → R=0x40, C=1 (amount wraps to 1). B=0 → R=A, C=0.
- MUL: A=0x12, B=0x34 → busy for 8 cycles, then R=0xA8, RH=0x03, C=1. A second start while busy and A/B reloads during the multiply do not change the result or timing.
- Back-to-back: a start of ADD in the done cycle of a MUL → ADD result one cycle later, and RH cleared to 0.
- Reset mid-MUL: assert reset_alu_core 3 cycles into a multiply → busy=0, done=0, R=RH=0, flags=0. A later A=0xFF, B=0xFF MUL → R=0x01, RH=0xFE.
